// File: rtl/store_rr_scheduler_pkg.sv
// rtl/store_rr_scheduler_pkg.sv - shared constants and width helpers for the store scheduler
package store_rr_scheduler_pkg;

    localparam int CTRL_W = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A single-port scheduler still carries a 1-bit pointer so no vector collapses to zero width.
    function automatic int ptr_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/store_rr_scheduler_rr_grant.sv
// rtl/store_rr_scheduler_rr_grant.sv - combinational round-robin pick starting at ptr
module rr_grant #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] idx
);

    int   pos;
    logic found;

    // Visit ports in the order ptr, ptr+1, ... wrapping, and take the first requester.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(ptr) + k) % N;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                idx        = PTR_W'(pos);
            end
        end
    end

endmodule

// File: rtl/store_rr_scheduler.sv
// rtl/store_rr_scheduler.sv - round-robin store scheduler sharing one BRAM write port
module store_rr_scheduler
    import store_rr_scheduler_pkg::*;
#(
    parameter int NUM_STORES   = 4,
    parameter int NUM_CONTROLS = 1,
    parameter int DATA_TYPE    = 32,
    parameter int ADDR_TYPE    = 32,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CONTROLS*CTRL_W-1:0] ctrl,
    input  logic [NUM_CONTROLS-1:0]        ctrl_valid,
    output logic [NUM_CONTROLS-1:0]        ctrl_ready,
    input  logic [NUM_STORES*ADDR_TYPE-1:0] stAddr,
    input  logic [NUM_STORES-1:0]          stAddr_valid,
    output logic [NUM_STORES-1:0]          stAddr_ready,
    input  logic [NUM_STORES*DATA_TYPE-1:0] stData,
    input  logic [NUM_STORES-1:0]          stData_valid,
    output logic [NUM_STORES-1:0]          stData_ready,
    input  logic                           wrStall,
    output logic                           storeEn,
    output logic [ADDR_TYPE-1:0]           storeAddr,
    output logic [DATA_TYPE-1:0]           storeData,
    output logic [CNT_WIDTH-1:0]           pending,
    output logic                           idle,
    output logic                           cntErr
);

    localparam int PTR_W = ptr_width(NUM_STORES);

    logic [NUM_STORES-1:0] req;
    logic [NUM_STORES-1:0] grant_raw;
    logic [NUM_STORES-1:0] grant;
    logic [PTR_W-1:0]      idx;
    logic                  fire;
    logic                  underflow;
    logic [ADDR_TYPE-1:0]  addr_sel;
    logic [DATA_TYPE-1:0]  data_sel;
    logic [CNT_WIDTH-1:0]  inc;

    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic                 store_en_q, store_en_d;
    logic [ADDR_TYPE-1:0] store_addr_q, store_addr_d;
    logic [DATA_TYPE-1:0] store_data_q, store_data_d;
    logic [CNT_WIDTH-1:0] pending_q, pending_d;
    logic                 cnt_err_q, cnt_err_d;

    // A port only competes once both its address and data are presented.
    assign req = stAddr_valid & stData_valid;

    rr_grant #(
        .N     (NUM_STORES),
        .PTR_W (PTR_W)
    ) u_rr_grant (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant_raw),
        .idx   (idx)
    );

    assign grant        = wrStall ? '0 : grant_raw;
    assign fire         = |grant;
    assign stAddr_ready = grant;
    assign stData_ready = grant;
    assign ctrl_ready   = '1;

    // Route the granted port's payload toward the output register.
    always_comb begin
        addr_sel = '0;
        data_sel = '0;
        for (int i = 0; i < NUM_STORES; i++) begin
            if (grant[i]) begin
                addr_sel = stAddr[i*ADDR_TYPE +: ADDR_TYPE];
                data_sel = stData[i*DATA_TYPE +: DATA_TYPE];
            end
        end
    end

    // Sum every store count announced this cycle, wrapping at the counter width.
    always_comb begin
        inc = '0;
        for (int i = 0; i < NUM_CONTROLS; i++) begin
            if (ctrl_valid[i]) begin
                inc = inc + CNT_WIDTH'(ctrl[i*CTRL_W +: CTRL_W]);
            end
        end
    end

    // Next write beat, rotating pointer and pending/underflow bookkeeping.
    always_comb begin
        ptr_d        = ptr_q;
        store_en_d   = fire;
        store_addr_d = store_addr_q;
        store_data_d = store_data_q;
        if (fire) begin
            store_addr_d = addr_sel;
            store_data_d = data_sel;
            ptr_d        = (idx == PTR_W'(NUM_STORES - 1)) ? '0 : idx + PTR_W'(1);
        end
        underflow = store_en_q && (pending_q == '0) && (inc == '0);
        pending_d = underflow ? '0 : pending_q + inc - CNT_WIDTH'(store_en_q);
        cnt_err_d = cnt_err_q | underflow;
    end

    // State register; reset drops the write strobe immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q        <= '0;
            store_en_q   <= 1'b0;
            store_addr_q <= '0;
            store_data_q <= '0;
            pending_q    <= '0;
            cnt_err_q    <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            store_en_q   <= store_en_d;
            store_addr_q <= store_addr_d;
            store_data_q <= store_data_d;
            pending_q    <= pending_d;
            cnt_err_q    <= cnt_err_d;
        end
    end

    assign storeEn   = store_en_q;
    assign storeAddr = store_addr_q;
    assign storeData = store_data_q;
    assign pending   = pending_q;
    assign cntErr    = cnt_err_q;
    assign idle      = (pending_q == '0) && (ctrl_valid == '0) && !store_en_q && !(|req);

endmodule

// File: tb/tb_store_rr_scheduler.sv
// tb/tb_store_rr_scheduler.sv - self-checking bench for store_rr_scheduler
module tb_store_rr_scheduler;

    logic         clk;
    logic         rst;
    logic [31:0]  ctrl;
    logic [0:0]   ctrl_valid;
    logic [0:0]   ctrl_ready;
    logic [127:0] stAddr;
    logic [3:0]   stAddr_valid;
    logic [3:0]   stAddr_ready;
    logic [127:0] stData;
    logic [3:0]   stData_valid;
    logic [3:0]   stData_ready;
    logic         wrStall;
    logic         storeEn;
    logic [31:0]  storeAddr;
    logic [31:0]  storeData;
    logic [31:0]  pending;
    logic         idle;
    logic         cntErr;

    logic [31:0] a [4];
    logic [31:0] d [4];

    assign stAddr = {a[3], a[2], a[1], a[0]};
    assign stData = {d[3], d[2], d[1], d[0]};

    store_rr_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .ctrl         (ctrl),
        .ctrl_valid   (ctrl_valid),
        .ctrl_ready   (ctrl_ready),
        .stAddr       (stAddr),
        .stAddr_valid (stAddr_valid),
        .stAddr_ready (stAddr_ready),
        .stData       (stData),
        .stData_valid (stData_valid),
        .stData_ready (stData_ready),
        .wrStall      (wrStall),
        .storeEn      (storeEn),
        .storeAddr    (storeAddr),
        .storeData    (storeData),
        .pending      (pending),
        .idle         (idle),
        .cntErr       (cntErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int gq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference model: state of the scheduler as the rules describe it.
    int          m_ptr, n_ptr, g, p;
    bit          m_en, n_en, m_err, n_err, e_idle;
    logic [31:0] m_addr, n_addr, m_data, n_data, m_pend, n_pend, inc;
    logic [3:0]  eg;

    always @(negedge clk) begin
        if (!rst) begin
            m_ptr = 0; m_en = 0; m_addr = 0; m_data = 0; m_pend = 0; m_err = 0;
        end
        g = -1;
        eg = 4'b0;
        if (!wrStall) begin
            for (int k = 0; k < 4; k++) begin
                p = (m_ptr + k) % 4;
                if (g < 0 && stAddr_valid[p] && stData_valid[p]) g = p;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        e_idle = (m_pend == 0) && (ctrl_valid == 0) && !m_en && ((stAddr_valid & stData_valid) == 0);
        chk("addr_ready", stAddr_ready, eg);
        chk("data_ready", stData_ready, eg);
        chk("ctrl_ready", ctrl_ready, 1);
        chk("storeEn", storeEn, m_en);
        chk("storeAddr", storeAddr, m_addr);
        chk("storeData", storeData, m_data);
        chk("pending", pending, m_pend);
        chk("idle", idle, e_idle);
        chk("cntErr", cntErr, m_err);
        for (int k = 0; k < 4; k++) if (stAddr_ready[k]) gq.push_back(k);
        n_en   = (g >= 0);
        n_addr = (g >= 0) ? a[g] : m_addr;
        n_data = (g >= 0) ? d[g] : m_data;
        n_ptr  = (g >= 0) ? (g + 1) % 4 : m_ptr;
        inc    = ctrl_valid[0] ? ctrl : 32'd0;
        if (m_en && m_pend == 0 && inc == 0) begin
            n_pend = 0;
            n_err  = 1;
        end else begin
            n_pend = m_pend + inc - 32'(m_en);
            n_err  = m_err;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_ptr = n_ptr; m_en = n_en; m_addr = n_addr; m_data = n_data;
            m_pend = n_pend; m_err = n_err;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int exp_pend [7] = '{5, 5, 4, 3, 2, 1, 0};

    initial begin
        rst = 1'b0; ctrl = 0; ctrl_valid = 0; wrStall = 0;
        for (int i = 0; i < 4; i++) begin
            a[i] = 32'h100 + i;
            d[i] = 32'hD0 + i;
        end
        stAddr_valid = 4'hF; stData_valid = 4'hF;
        cyc(); cyc(); #1;
        chk("rst_storeEn", storeEn, 0);
        chk("rst_pending", pending, 0);
        chk("rst_cntErr", cntErr, 0);
        stAddr_valid = 0; stData_valid = 0; #1;
        chk("rst_idle", idle, 1);
        cyc(); rst = 1'b1;
        cyc(); #1;
        chk("post_rst_idle", idle, 1);
        chk("post_rst_storeEn", storeEn, 0);

        // fairness: every port requesting, pointer starts at 0
        gq.delete();
        cyc(); ctrl = 8; ctrl_valid = 1; stAddr_valid = 4'hF; stData_valid = 4'hF; #1;
        chk("fair_first_ready", stAddr_ready, 4'b0001);
        cyc(); ctrl_valid = 0; #1;
        chk("fair_addr_lag", storeAddr, 32'h100);
        chk("fair_data_lag", storeData, 32'hD0);
        repeat (6) cyc();
        cyc(); stAddr_valid = 0; stData_valid = 0; #1;
        chk("fair_last_addr", storeAddr, 32'h103);
        for (int i = 0; i < 8; i++) chk("fair_order", (i < gq.size()) ? gq[i] : -1, i % 4);
        cyc(); cyc(); #1;
        chk("fair_pending_zero", pending, 0);
        chk("fair_idle", idle, 1);

        // split handshake on port 2
        cyc(); ctrl = 1; ctrl_valid = 1; stAddr_valid = 4'b0100; #1;
        chk("split_c0", stAddr_ready, 0);
        cyc(); ctrl_valid = 0; #1;
        chk("split_c1", stAddr_ready, 0);
        cyc(); #1;
        chk("split_c2", stAddr_ready, 0);
        cyc(); stData_valid = 4'b0100; #1;
        chk("split_c3_ready", stAddr_ready, 4'b0100);
        chk("split_c3_en", storeEn, 0);
        cyc(); stAddr_valid = 0; stData_valid = 0; #1;
        chk("split_c4_en", storeEn, 1);
        chk("split_c4_addr", storeAddr, 32'h102);

        // one store on port 0 moves the pointer to 1
        cyc(); ctrl = 1; ctrl_valid = 1; stAddr_valid = 4'b0001; stData_valid = 4'b0001;
        cyc(); ctrl_valid = 0; stAddr_valid = 0; stData_valid = 0; #1;
        chk("p0_addr", storeAddr, 32'h100);

        // stall with ports 1 and 3 requesting
        cyc(); ctrl = 2; ctrl_valid = 1; wrStall = 1; stAddr_valid = 4'b1010; stData_valid = 4'b1010; #1;
        chk("stall_c0", stAddr_ready, 0);
        cyc(); ctrl_valid = 0; #1;
        chk("stall_c1", stAddr_ready, 0);
        chk("stall_c1_en", storeEn, 0);
        cyc(); #1;
        chk("stall_c2", stData_ready, 0);
        chk("stall_c2_en", storeEn, 0);
        gq.delete();
        cyc(); wrStall = 0; #1;
        chk("unstall_1", stAddr_ready, 4'b0010);
        cyc(); #1;
        chk("unstall_3", stAddr_ready, 4'b1000);
        chk("unstall_addr1", storeAddr, 32'h101);
        cyc(); stAddr_valid = 0; stData_valid = 0; #1;
        chk("unstall_addr3", storeAddr, 32'h103);
        chk("unstall_order0", (gq.size() > 0) ? gq[0] : -1, 1);
        chk("unstall_order1", (gq.size() > 1) ? gq[1] : -1, 3);
        cyc(); cyc(); #1;
        chk("stall_pending_zero", pending, 0);

        // counter: announce 5, then 5 stores
        cyc(); ctrl = 5; ctrl_valid = 1;
        cyc(); ctrl_valid = 0; stAddr_valid = 4'b0001; stData_valid = 4'b0001;
        for (int k = 0; k < 7; k++) begin
            if (k > 0) cyc();
            if (k == 5) begin stAddr_valid = 0; stData_valid = 0; end
            #1;
            chk("cnt_pending", pending, exp_pend[k]);
        end
        chk("cnt_idle", idle, 1);

        // increment and decrement in the same cycle
        cyc(); ctrl = 3; ctrl_valid = 1;
        cyc(); ctrl_valid = 0; stAddr_valid = 4'b0001; stData_valid = 4'b0001;
        cyc(); stAddr_valid = 0; stData_valid = 0; ctrl = 2; ctrl_valid = 1; #1;
        chk("both_en", storeEn, 1);
        chk("both_pre", pending, 3);
        cyc(); ctrl_valid = 0; #1;
        chk("both_post", pending, 4);
        cyc(); stAddr_valid = 4'b0001; stData_valid = 4'b0001;
        repeat (3) cyc();
        cyc(); stAddr_valid = 0; stData_valid = 0;
        cyc(); cyc(); #1;
        chk("drain_pending", pending, 0);
        chk("drain_cntErr", cntErr, 0);

        // underflow: store with nothing announced
        cyc(); stAddr_valid = 4'b0001; stData_valid = 4'b0001;
        cyc(); stAddr_valid = 0; stData_valid = 0; #1;
        chk("uf_en", storeEn, 1);
        chk("uf_err_before", cntErr, 0);
        cyc(); #1;
        chk("uf_pending", pending, 0);
        chk("uf_err", cntErr, 1);
        cyc(); cyc(); #1;
        chk("uf_err_sticky", cntErr, 1);

        // reset in the middle of a write beat
        cyc(); stAddr_valid = 4'b0001; stData_valid = 4'b0001;
        cyc(); #1;
        chk("mid_en", storeEn, 1);
        rst = 1'b0; #1;
        chk("mid_rst_en", storeEn, 0);
        chk("mid_rst_err", cntErr, 0);
        chk("mid_rst_pending", pending, 0);
        stAddr_valid = 0; stData_valid = 0;
        cyc(); rst = 1'b1;
        cyc(); #1;
        chk("mid_rst_idle", idle, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
